ahb_ifdm_arbiter: RTL and testbench

AHB_IFDM_ARBITER -- requirements
Module: ahb_ifdm_arbiter

---
 rtl/ahb_ifdm_arbiter.sv | 99 +++++++++
 tb/tb_ahb_ifdm_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_ifdm_arbiter.sv
// Two-master AHB-Lite arbiter: a data (load/store) port and an instruction fetch port
// share one AHB master interface, with a bounded wait counter so neither side starves.
module ahb_ifdm_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        d_ack,
  output logic        i_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2} owner_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

  owner_t      r_owner, w_owner_nxt;
  logic [3:0]  r_wait_cnt, w_wait_nxt;
  logic [31:0] r_hwdata;

  logic w_def_req, w_oth_req, w_win_def, w_win_oth, w_win_d, w_win_i;
  logic w_cancel, w_nonseq, w_gnt_def, w_gnt_oth, w_ack;

  // "def" is the default-priority side, "oth" the side protected by the wait counter
  assign w_def_req = DATA_PRIO ? d_req : i_req;
  assign w_oth_req = DATA_PRIO ? i_req : d_req;
  assign w_win_def = w_def_req && !((r_wait_cnt == LP_MAX) && w_oth_req);
  assign w_win_oth = w_oth_req && !w_win_def;
  assign w_win_d   = DATA_PRIO ? w_win_def : w_win_oth;
  assign w_win_i   = DATA_PRIO ? w_win_oth : w_win_def;

  // First cycle of a two-cycle ERROR response: the pending address phase must be withdrawn
  assign w_cancel = HRESP && !HREADY;
  assign w_nonseq = (w_win_d || w_win_i) && !w_cancel && HRESETn;

  assign HTRANS = w_nonseq ? 2'b10 : 2'b00;
  assign HADDR  = w_win_d ? d_addr : i_addr;
  assign HWRITE = w_win_d && d_we;
  assign HSIZE  = w_win_d ? d_size : 3'b010;
  assign HWDATA = r_hwdata;

  assign d_gnt     = w_nonseq && HREADY && w_win_d;
  assign i_gnt     = w_nonseq && HREADY && w_win_i;
  assign w_gnt_def = DATA_PRIO ? d_gnt : i_gnt;
  assign w_gnt_oth = DATA_PRIO ? i_gnt : d_gnt;

  assign d_ack     = (r_owner == OWN_D) && HREADY;
  assign i_ack     = (r_owner == OWN_I) && HREADY;
  assign w_ack     = d_ack || i_ack;
  assign rsp_rdata = w_ack ? HRDATA : 32'h0;
  assign rsp_err   = w_ack && HRESP;

  always_comb begin
    w_owner_nxt = r_owner;
    w_wait_nxt  = r_wait_cnt;
    if (HREADY) begin
      if (d_gnt)      w_owner_nxt = OWN_D;
      else if (i_gnt) w_owner_nxt = OWN_I;
      else            w_owner_nxt = OWN_NONE;
    end
    if (!w_oth_req || w_gnt_oth)
      w_wait_nxt = 4'd0;
    else if (w_gnt_def && (r_wait_cnt != LP_MAX))
      w_wait_nxt = r_wait_cnt + 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= 4'd0;
      r_hwdata   <= 32'h0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (d_gnt && d_we)
        r_hwdata <= d_wdata;
    end
  end

endmodule

// File: tb/tb_ahb_ifdm_arbiter.sv
// Directed bench for ahb_ifdm_arbiter: priority, starvation bound, wait states,
// ERROR response, pipelined fetches and mid-transfer reset.
module tb_ahb_ifdm_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        d_req, d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, d_ack, i_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int nchk = 0;
  int nerr = 0;

  always #5 HCLK = ~HCLK;

  ahb_ifdm_arbiter #(.MAX_WAIT(4), .DATA_PRIO(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .d_ack(d_ack), .i_ack(i_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h0;
    d_wdata = 32'hFFFF_FFFF; i_req = 1'b1; i_addr = 32'h0; HRDATA = 32'hA5A5_A5A5;
    HREADY = 1'b1; HRESP = 1'b0;

    // Reset state with requests active
    cyc(); cyc(); #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_acks", {d_ack, i_ack}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_hwdata", HWDATA, 0);

    // Both request, data has priority
    cyc();
    HRESETn = 1'b1; d_req = 1'b1; d_we = 1'b0; d_size = 3'b001; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h200; #1;
    chk("prio_d_gnt", d_gnt, 1);
    chk("prio_i_gnt", i_gnt, 0);
    chk("prio_haddr", HADDR, 32'h100);
    chk("prio_htrans", HTRANS, 2'b10);
    chk("prio_hsize", HSIZE, 3'b001);
    cyc();
    d_req = 1'b0; HRDATA = 32'h1111_2222; #1;
    chk("prio_i_gnt2", i_gnt, 1);
    chk("prio_haddr2", HADDR, 32'h200);
    chk("prio_hsize2", HSIZE, 3'b010);
    chk("prio_hwrite2", HWRITE, 0);
    chk("prio_d_ack", d_ack, 1);
    chk("prio_rdata", rsp_rdata, 32'h1111_2222);
    cyc();
    i_req = 1'b0; #1;
    chk("prio_i_ack", i_ack, 1);
    chk("prio_idle", HTRANS, 2'b00);

    // Starvation bound: four data grants then one fetch grant, then data again
    cyc();
    d_req = 1'b1; i_req = 1'b1; #1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wait_d_gnt%0d", k), d_gnt, (k == 4) ? 0 : 1);
      chk($sformatf("wait_i_gnt%0d", k), i_gnt, (k == 4) ? 1 : 0);
      cyc(); #1;
    end
    d_req = 1'b0; i_req = 1'b0;
    cyc(); cyc(); #1;
    chk("wait_drained", {d_ack, i_ack}, 0);

    // Store with two wait states in the data phase
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF; #1;
    chk("st_gnt", d_gnt, 1);
    chk("st_hwrite", HWRITE, 1);
    chk("st_haddr", HADDR, 32'h1000);
    cyc();
    d_req = 1'b0; d_wdata = 32'h1234_5678; HREADY = 1'b0; #1;
    chk("st_hwdata0", HWDATA, 32'hDEAD_BEEF);
    chk("st_ack0", d_ack, 0);
    cyc(); #1;
    chk("st_hwdata1", HWDATA, 32'hDEAD_BEEF);
    chk("st_ack1", d_ack, 0);
    cyc();
    HREADY = 1'b1; #1;
    chk("st_hwdata2", HWDATA, 32'hDEAD_BEEF);
    chk("st_ack2", d_ack, 1);
    cyc(); #1;
    chk("st_ack_done", d_ack, 0);

    // Fetch receiving a two-cycle ERROR response, with a data request pending
    cyc();
    d_we = 1'b0; i_req = 1'b1; i_addr = 32'h10; #1;
    chk("err_i_gnt", i_gnt, 1);
    cyc();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h300; HRESP = 1'b1; HREADY = 1'b0; #1;
    chk("err_htrans_idle", HTRANS, 2'b00);
    chk("err_no_gnt", d_gnt, 0);
    chk("err_no_ack", i_ack, 0);
    cyc();
    HREADY = 1'b1; #1;
    chk("err_i_ack", i_ack, 1);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_d_gnt", d_gnt, 1);
    cyc();
    d_req = 1'b0; HRESP = 1'b0; HRDATA = 32'h0BAD_F00D; #1;
    chk("err_d_ack", d_ack, 1);
    chk("err_clear", rsp_err, 0);
    chk("err_d_rdata", rsp_rdata, 32'h0BAD_F00D);

    // Back-to-back fetches
    cyc();
    i_req = 1'b1; i_addr = 32'h0; #1;
    chk("b2b_gnt0", i_gnt, 1);
    chk("b2b_haddr0", HADDR, 32'h0);
    chk("b2b_noack0", i_ack, 0);
    cyc();
    i_addr = 32'h4; HRDATA = 32'hC000_0000; #1;
    chk("b2b_gnt1", i_gnt, 1);
    chk("b2b_haddr1", HADDR, 32'h4);
    chk("b2b_ack1", i_ack, 1);
    chk("b2b_rdata1", rsp_rdata, 32'hC000_0000);
    cyc();
    i_addr = 32'h8; HRDATA = 32'hC000_0004; #1;
    chk("b2b_gnt2", i_gnt, 1);
    chk("b2b_haddr2", HADDR, 32'h8);
    chk("b2b_ack2", i_ack, 1);
    chk("b2b_rdata2", rsp_rdata, 32'hC000_0004);
    cyc();
    i_req = 1'b0; HRDATA = 32'hC000_0008; #1;
    chk("b2b_nogt3", i_gnt, 0);
    chk("b2b_ack3", i_ack, 1);
    chk("b2b_rdata3", rsp_rdata, 32'hC000_0008);
    cyc(); #1;
    chk("b2b_ack4", i_ack, 0);

    // Reset during a stalled data phase
    cyc();
    d_req = 1'b1; d_addr = 32'h2000; #1;
    chk("rr_gnt", d_gnt, 1);
    cyc();
    d_req = 1'b0; HREADY = 1'b0; #1;
    chk("rr_stall_ack", d_ack, 0);
    #1; HRESETn = 1'b0; #1;
    chk("rr_in_rst_htrans", HTRANS, 2'b00);
    chk("rr_in_rst_ack", d_ack, 0);
    cyc();
    HREADY = 1'b1; d_req = 1'b1; d_addr = 32'h2004; #1;
    chk("rr_rst_ready_ack", d_ack, 0);
    chk("rr_rst_gnt", d_gnt, 0);
    cyc();
    HRESETn = 1'b1; #1;
    chk("rr_post_gnt", d_gnt, 1);
    chk("rr_post_ack", d_ack, 0);
    chk("rr_post_haddr", HADDR, 32'h2004);
    cyc();
    d_req = 1'b0; #1;
    chk("rr_new_ack", d_ack, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
